// File: rtl/sprite_pkg.sv
// Shared types and screen geometry for the sprite motion sequencer.
package sprite_pkg;

    // Coordinate widths of the sprite origin.
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;

    // Default screen bounds; the minimum on both axes is 0.
    localparam int unsigned X_MAX_DEFAULT = 144;
    localparam int unsigned Y_MAX_DEFAULT = 112;

    // Width of the shift_amount command field.
    localparam int unsigned SHW = 7;

    typedef enum logic [1:0] {
        DirRight = 2'b00,
        DirLeft  = 2'b01,
        DirDown  = 2'b10,
        DirUp    = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StClrArm = 3'd1,
        StClrRun = 3'd2,
        StMove   = 3'd3,
        StDrwArm = 3'd4,
        StDrwRun = 3'd5
    } state_e;

endpackage

// File: rtl/sprite_motion_sequencer_if.sv
// Frame request and sprite engine command bundle between the sequencer and its neighbours.
interface sprite_motion_sequencer_if;
    import sprite_pkg::*;

    logic              frame_tick;
    logic              move_en;
    logic [1:0]        dir;
    logic              sprite_complete;
    logic              draw;
    logic              clear;
    logic              shift_h;
    logic              shift_v;
    logic              load;
    logic [SHW-1:0]    shift_amount;
    logic [XW-1:0]     load_x;
    logic [YW-1:0]     load_y;
    logic [XW-1:0]     pos_x;
    logic [YW-1:0]     pos_y;
    logic              busy;
    logic              overrun;
    logic              timeout_err;

    // Requester / sprite engine side.
    modport master (
        output frame_tick, move_en, dir, sprite_complete,
        input  draw, clear, shift_h, shift_v, load, shift_amount,
        input  load_x, load_y, pos_x, pos_y, busy, overrun, timeout_err
    );

    // Sequencer side.
    modport slave (
        input  frame_tick, move_en, dir, sprite_complete,
        output draw, clear, shift_h, shift_v, load, shift_amount,
        output load_x, load_y, pos_x, pos_y, busy, overrun, timeout_err
    );

endinterface

// File: rtl/sprite_pos_clamp.sv
// Combinational saturating position update: pos +/- STEP along dir, held in [0, max].
module sprite_pos_clamp
    import sprite_pkg::*;
#(
    parameter int unsigned STEP  = 1,
    parameter int unsigned X_MAX = X_MAX_DEFAULT,
    parameter int unsigned Y_MAX = Y_MAX_DEFAULT
) (
    input  logic [XW-1:0] pos_x_i,
    input  logic [YW-1:0] pos_y_i,
    input  dir_e          dir_i,
    input  logic          move_en_i,
    output logic [XW-1:0] cand_x_o,
    output logic [YW-1:0] cand_y_o
);

    // Work in 16 bits so neither pos + STEP nor the underflow test can wrap.
    localparam logic [15:0] StepW = 16'(STEP);
    localparam logic [15:0] XMaxW = 16'(X_MAX);
    localparam logic [15:0] YMaxW = 16'(Y_MAX);

    logic [15:0] x_w;
    logic [15:0] y_w;

    // Step along the requested axis, saturating at both screen edges.
    always_comb begin
        x_w = 16'(pos_x_i);
        y_w = 16'(pos_y_i);
        if (move_en_i) begin
            unique case (dir_i)
                DirRight: x_w = (x_w + StepW > XMaxW) ? XMaxW : x_w + StepW;
                DirLeft:  x_w = (x_w < StepW) ? 16'd0 : x_w - StepW;
                DirDown:  y_w = (y_w + StepW > YMaxW) ? YMaxW : y_w + StepW;
                DirUp:    y_w = (y_w < StepW) ? 16'd0 : y_w - StepW;
            endcase
        end
        // Also pull back an out-of-range start position (e.g. a bad INIT parameter).
        if (x_w > XMaxW) x_w = XMaxW;
        if (y_w > YMaxW) y_w = YMaxW;
        cand_x_o = x_w[XW-1:0];
        cand_y_o = y_w[YW-1:0];
    end

endmodule

// File: rtl/sprite_motion_sequencer.sv
// Per-frame sprite sequencer: erase the old sprite, move its origin, redraw it.
module sprite_motion_sequencer
    import sprite_pkg::*;
#(
    parameter int unsigned X_INIT  = 49,
    parameter int unsigned Y_INIT  = 48,
    parameter int unsigned X_MAX   = X_MAX_DEFAULT,
    parameter int unsigned Y_MAX   = Y_MAX_DEFAULT,
    parameter int unsigned STEP    = 1,
    parameter int unsigned TIMEOUT = 1023
) (
    input logic                     clk,
    input logic                     resetn,
    sprite_motion_sequencer_if.slave bus
);

    localparam int unsigned CntW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    // Value of the run counter during the last run cycle before the abort.
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            move_en_q, move_en_d;
    dir_e            dir_q, dir_d;
    logic            draw_q, draw_d;
    logic            clear_q, clear_d;
    logic            shift_h_q, shift_h_d;
    logic            load_q, load_d;
    logic            busy_q, busy_d;
    logic            overrun_q, overrun_d;
    logic            timeout_q, timeout_d;
    logic [XW-1:0]   load_x_q, load_x_d, pos_x_q, pos_x_d, cand_x;
    logic [YW-1:0]   load_y_q, load_y_d, pos_y_q, pos_y_d, cand_y;

    sprite_pos_clamp #(
        .STEP  (STEP),
        .X_MAX (X_MAX),
        .Y_MAX (Y_MAX)
    ) u_clamp (
        .pos_x_i   (pos_x_q),
        .pos_y_i   (pos_y_q),
        .dir_i     (dir_q),
        .move_en_i (move_en_q),
        .cand_x_o  (cand_x),
        .cand_y_o  (cand_y)
    );

    // Next state, run-phase watchdog, sticky flags and strobes decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        move_en_d = move_en_q;
        dir_d     = dir_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q | (bus.frame_tick & (state_q != StIdle));

        unique case (state_q)
            StIdle: begin
                if (bus.frame_tick) begin
                    state_d   = StClrArm;
                    move_en_d = bus.move_en;
                    dir_d     = dir_e'(bus.dir);
                end
            end
            // Engine pointer may still read as wrapped from the last pass; complete is ignored.
            StClrArm: state_d = StClrRun;
            StClrRun: begin
                if (bus.sprite_complete) begin
                    state_d = StMove;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StMove:   state_d = StDrwArm;
            StDrwArm: state_d = StDrwRun;
            StDrwRun: begin
                if (bus.sprite_complete) begin
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Strobes are registered from the next state so they line up with state_q.
        draw_d    = state_d inside {StClrArm, StClrRun, StDrwArm, StDrwRun};
        clear_d   = state_d inside {StClrArm, StClrRun};
        shift_h_d = state_d inside {StDrwArm, StDrwRun};
        load_d    = (state_d == StMove);
        busy_d    = (state_d != StIdle);

        load_x_d = (state_d == StMove) ? cand_x : load_x_q;
        load_y_d = (state_d == StMove) ? cand_y : load_y_q;
        pos_x_d  = (state_q == StMove) ? load_x_q : pos_x_q;
        pos_y_d  = (state_q == StMove) ? load_y_q : pos_y_q;
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            move_en_q <= 1'b0;
            dir_q     <= DirRight;
            draw_q    <= 1'b0;
            clear_q   <= 1'b0;
            shift_h_q <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            load_x_q  <= XW'(X_INIT);
            load_y_q  <= YW'(Y_INIT);
            pos_x_q   <= XW'(X_INIT);
            pos_y_q   <= YW'(Y_INIT);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            move_en_q <= move_en_d;
            dir_q     <= dir_d;
            draw_q    <= draw_d;
            clear_q   <= clear_d;
            shift_h_q <= shift_h_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            load_x_q  <= load_x_d;
            load_y_q  <= load_y_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
        end
    end

    assign bus.draw         = draw_q;
    assign bus.clear        = clear_q;
    assign bus.shift_h      = shift_h_q;
    assign bus.shift_v      = 1'b0;
    assign bus.load         = load_q;
    assign bus.shift_amount = SHW'(STEP);
    assign bus.load_x       = load_x_q;
    assign bus.load_y       = load_y_q;
    assign bus.pos_x        = pos_x_q;
    assign bus.pos_y        = pos_y_q;
    assign bus.busy         = busy_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout_err  = timeout_q;

endmodule
